// File: rtl/lsu_mem_stage.sv
// ============================================================================
// Module   : lsu_mem_stage
// Purpose  : MEM-stage load/store unit driving a variable-latency req/ack bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic            op_load,
    input  logic [1:0]      op_size,
    input  logic            op_unsigned,
    input  logic [XLEN-1:0] op_addr,
    input  logic [XLEN-1:0] op_wdata,
    input  logic [4:0]      op_rd,
    output logic            stall_o,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_adr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [XLEN/8-1:0] bus_mask,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_err,
    output logic            ld_valid,
    output logic [XLEN-1:0] ld_data,
    output logic [4:0]      ld_rd,
    output logic            exc_valid,
    output logic [1:0]      exc_cause,
    output logic [XLEN-1:0] exc_addr
);

    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [1:0]  c_CAUSE_ACCESS  = 2'b10;
    localparam logic [1:0]  c_CAUSE_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RESP  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          state_q;
    logic [15:0]     cnt_q;
    logic [XLEN-1:0] addr_q;
    logic            load_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic [4:0]      rd_q;
    logic            bus_we_q;
    logic [XLEN-1:0] bus_adr_q;
    logic [XLEN-1:0] bus_wdata_q;
    logic [NB-1:0]   bus_mask_q;
    logic            ld_valid_q;
    logic [XLEN-1:0] ld_data_q;
    logic [4:0]      ld_rd_q;
    logic            exc_valid_q;
    logic [1:0]      exc_cause_q;
    logic [XLEN-1:0] exc_addr_q;

    logic                   w_size_ill;
    logic [2:0]             w_amask;
    logic                   w_misal;
    logic [NB-1:0]          w_mask_base;
    logic [XLEN-1:0]        w_wdata;
    logic [XLEN-1:0]        w_shifted;
    logic [6:0]             w_ext_sh;
    logic [XLEN-1:0]        w_left;
    logic signed [XLEN-1:0] w_left_s;
    logic [XLEN-1:0]        w_ld;

    assign w_size_ill = (op_size == 2'b11) && (XLEN == 32);
    assign w_amask    = 3'((4'd1 << op_size) - 4'd1);
    assign w_misal    = (op_addr[2:0] & w_amask) != 3'd0;

    always_comb begin
        w_mask_base = '0;
        w_wdata     = '0;
        case (op_size)
            2'b00: begin
                w_mask_base = NB'(1);
                w_wdata     = {NB{op_wdata[7:0]}};
            end
            2'b01: begin
                w_mask_base = NB'(3);
                w_wdata     = {(NB/2){op_wdata[15:0]}};
            end
            2'b10: begin
                w_mask_base = NB'(15);
                w_wdata     = {(NB/4){op_wdata[31:0]}};
            end
            default: begin
                w_mask_base = {NB{1'b1}};
                w_wdata     = op_wdata;
            end
        endcase
    end

    // Extend by pushing the field to the MSB end and shifting back; a zero shift keeps doubles whole.
    assign w_shifted = bus_rdata >> {addr_q[LW-1:0], 3'b000};
    assign w_ext_sh  = 7'(XLEN) - (7'd8 << size_q);
    assign w_left    = w_shifted << w_ext_sh;
    assign w_left_s  = w_left;
    assign w_ld      = unsigned_q ? (w_left >> w_ext_sh) : $unsigned(w_left_s >>> w_ext_sh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            load_q      <= 1'b0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            rd_q        <= '0;
            bus_we_q    <= 1'b0;
            bus_adr_q   <= '0;
            bus_wdata_q <= '0;
            bus_mask_q  <= '0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            ld_rd_q     <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= '0;
            exc_addr_q  <= '0;
        end else begin
            ld_valid_q  <= 1'b0;
            exc_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (op_valid) begin
                        addr_q     <= op_addr;
                        load_q     <= op_load;
                        size_q     <= op_size;
                        unsigned_q <= op_unsigned;
                        rd_q       <= op_rd;
                        if (w_size_ill || w_misal) begin
                            exc_valid_q <= 1'b1;
                            exc_addr_q  <= op_addr;
                            exc_cause_q <= w_size_ill ? c_CAUSE_ACCESS : {1'b0, ~op_load};
                            state_q     <= S_FAULT;
                        end else begin
                            bus_we_q    <= ~op_load;
                            bus_adr_q   <= op_addr & ~XLEN'(NB - 1);
                            bus_wdata_q <= w_wdata;
                            bus_mask_q  <= w_mask_base << op_addr[LW-1:0];
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (bus_ack) begin
                        if (bus_err) begin
                            exc_valid_q <= 1'b1;
                            exc_addr_q  <= addr_q;
                            exc_cause_q <= c_CAUSE_ACCESS;
                            state_q     <= S_FAULT;
                        end else begin
                            ld_valid_q <= load_q;
                            if (load_q) begin
                                ld_data_q <= w_ld;
                                ld_rd_q   <= rd_q;
                            end
                            state_q <= S_RESP;
                        end
                    end else if (cnt_q == c_TMO_LAST) begin
                        exc_valid_q <= 1'b1;
                        exc_addr_q  <= addr_q;
                        exc_cause_q <= c_CAUSE_TIMEOUT;
                        state_q     <= S_FAULT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The accept cycle must stall before the state register has moved.
    assign stall_o   = (state_q == S_REQ) || (state_q == S_IDLE && op_valid && !rst);
    assign bus_req   = (state_q == S_REQ);
    assign bus_we    = bus_we_q;
    assign bus_adr   = bus_adr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_mask  = bus_mask_q;
    assign ld_valid  = ld_valid_q;
    assign ld_data   = ld_data_q;
    assign ld_rd     = ld_rd_q;
    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;
    assign exc_addr  = exc_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
// ============================================================================
// Module   : tb_lsu_mem_stage
// Purpose  : Directed self-checking bench for lsu_mem_stage (XLEN 32 and 64).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid32, op_valid64;
    logic        op_load, op_uns;
    logic [1:0]  op_size;
    logic [63:0] op_addr, op_wdata, rdata;
    logic [4:0]  op_rd;
    logic        ack32, ack64, err;

    logic        stall32, req32, we32, ldv32, excv32;
    logic [31:0] adr32, wdata32, ldd32, exca32;
    logic [3:0]  mask32;
    logic [4:0]  ldrd32;
    logic [1:0]  cause32;

    logic        stall64, req64, we64, ldv64, excv64;
    logic [63:0] adr64, wdata64, ldd64, exca64;
    logic [7:0]  mask64;
    logic [4:0]  ldrd64;
    logic [1:0]  cause64;

    int n_checks = 0;
    int n_err    = 0;
    int ns, nr;

    always #5 clk = ~clk;

    lsu_mem_stage #(.XLEN(32), .TIMEOUT(16)) dut32 (
        .clk(clk), .rst(rst), .op_valid(op_valid32), .op_load(op_load), .op_size(op_size),
        .op_unsigned(op_uns), .op_addr(op_addr[31:0]), .op_wdata(op_wdata[31:0]), .op_rd(op_rd),
        .stall_o(stall32), .bus_req(req32), .bus_we(we32), .bus_adr(adr32), .bus_wdata(wdata32),
        .bus_mask(mask32), .bus_ack(ack32), .bus_rdata(rdata[31:0]), .bus_err(err),
        .ld_valid(ldv32), .ld_data(ldd32), .ld_rd(ldrd32), .exc_valid(excv32),
        .exc_cause(cause32), .exc_addr(exca32)
    );

    lsu_mem_stage #(.XLEN(64), .TIMEOUT(16)) dut64 (
        .clk(clk), .rst(rst), .op_valid(op_valid64), .op_load(op_load), .op_size(op_size),
        .op_unsigned(op_uns), .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
        .stall_o(stall64), .bus_req(req64), .bus_we(we64), .bus_adr(adr64), .bus_wdata(wdata64),
        .bus_mask(mask64), .bus_ack(ack64), .bus_rdata(rdata), .bus_err(err),
        .ld_valid(ldv64), .ld_data(ldd64), .ld_rd(ldrd64), .exc_valid(excv64),
        .exc_cause(cause64), .exc_addr(exca64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit is64, input logic ld, input logic [1:0] sz, input logic uns,
                         input logic [63:0] a, input logic [63:0] wd, input logic [4:0] rd);
        op_load    = ld;
        op_size    = sz;
        op_uns     = uns;
        op_addr    = a;
        op_wdata   = wd;
        op_rd      = rd;
        op_valid32 = !is64;
        op_valid64 = is64;
    endtask

    initial begin
        rst = 1'b1;
        op_valid32 = 0; op_valid64 = 0; op_load = 0; op_uns = 0; op_size = 0;
        op_addr = 0; op_wdata = 0; op_rd = 0; rdata = 0; ack32 = 0; ack64 = 0; err = 0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 64'(stall32), 64'd0);
        chk("rst_req", 64'(req32), 64'd0);
        chk("rst_ld_data", 64'(ldd32), 64'd0);
        chk("rst_exc", 64'(excv32), 64'd0);
        rst = 1'b0;

        // LB at 0x1003, sign-extended
        @(negedge clk);
        drive(0, 1, 2'b00, 0, 64'h1003, 64'h0, 5'd7);
        #1 chk("lb_accept_stall", 64'(stall32), 64'd1);
        @(negedge clk);
        chk("lb_req", 64'(req32), 64'd1);
        chk("lb_adr", 64'(adr32), 64'h1000);
        chk("lb_mask", 64'(mask32), 64'b1000);
        chk("lb_we", 64'(we32), 64'd0);
        rdata = 64'h8000_0000; ack32 = 1;
        @(negedge clk);
        ack32 = 0; op_valid32 = 0;
        chk("lb_ld_valid", 64'(ldv32), 64'd1);
        chk("lb_ld_data", 64'(ldd32), 64'hFFFF_FF80);
        chk("lb_ld_rd", 64'(ldrd32), 64'd7);
        chk("lb_resp_stall", 64'(stall32), 64'd0);
        @(negedge clk);
        chk("lb_pulse_end", 64'(ldv32), 64'd0);
        chk("lb_data_hold", 64'(ldd32), 64'hFFFF_FF80);

        // LBU at 0x1003
        drive(0, 1, 2'b00, 1, 64'h1003, 64'h0, 5'd8);
        @(negedge clk);
        rdata = 64'h8000_0000; ack32 = 1;
        @(negedge clk);
        ack32 = 0; op_valid32 = 0;
        chk("lbu_ld_data", 64'(ldd32), 64'h0000_0080);
        chk("lbu_ld_valid", 64'(ldv32), 64'd1);
        @(negedge clk);

        // SH at 0x2002
        drive(0, 0, 2'b01, 0, 64'h2002, 64'h0000_BEEF, 5'd0);
        @(negedge clk);
        chk("sh_we", 64'(we32), 64'd1);
        chk("sh_wdata", 64'(wdata32), 64'hBEEF_BEEF);
        chk("sh_mask", 64'(mask32), 64'b1100);
        chk("sh_adr", 64'(adr32), 64'h2000);
        ack32 = 1;
        @(negedge clk);
        ack32 = 0; op_valid32 = 0;
        chk("sh_resp_ldv", 64'(ldv32), 64'd0);
        chk("sh_resp_stall", 64'(stall32), 64'd0);
        @(negedge clk);
        chk("sh_after_ldv", 64'(ldv32), 64'd0);

        // LW at 0x1001, misaligned
        drive(0, 1, 2'b10, 0, 64'h1001, 64'h0, 5'd1);
        #1 chk("lwmis_stall", 64'(stall32), 64'd1);
        chk("lwmis_noreq", 64'(req32), 64'd0);
        @(negedge clk);
        op_valid32 = 0;
        chk("lwmis_stall_drop", 64'(stall32), 64'd0);
        chk("lwmis_noreq2", 64'(req32), 64'd0);
        chk("lwmis_exc", 64'(excv32), 64'd1);
        chk("lwmis_cause", 64'(cause32), 64'd0);
        chk("lwmis_addr", 64'(exca32), 64'h1001);
        @(negedge clk);
        chk("lwmis_exc_end", 64'(excv32), 64'd0);

        // SW at 0x1002, misaligned store
        drive(0, 0, 2'b10, 0, 64'h1002, 64'h0, 5'd0);
        @(negedge clk);
        op_valid32 = 0;
        chk("swmis_cause", 64'(cause32), 64'd1);
        chk("swmis_exc", 64'(excv32), 64'd1);
        @(negedge clk);

        // Double on a 32-bit unit
        drive(0, 1, 2'b11, 0, 64'h1000, 64'h0, 5'd0);
        @(negedge clk);
        op_valid32 = 0;
        chk("ld32_cause", 64'(cause32), 64'd2);
        chk("ld32_noreq", 64'(req32), 64'd0);
        @(negedge clk);

        // LW with ack in the 5th REQ cycle
        ns = 0;
        drive(0, 1, 2'b10, 0, 64'h3000, 64'h0, 5'd2);
        #1 if (stall32) ns++;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (stall32) ns++;
            if (k == 5) begin
                rdata = 64'h1234_5678; ack32 = 1;
            end
        end
        @(negedge clk);
        ack32 = 0; op_valid32 = 0;
        chk("wait5_stall_cycles", 64'(ns), 64'd6);
        chk("wait5_resp_stall", 64'(stall32), 64'd0);
        chk("wait5_ldv", 64'(ldv32), 64'd1);
        chk("wait5_data", 64'(ldd32), 64'h1234_5678);
        @(negedge clk);

        // LW with no ack, timeout after 16 REQ cycles
        drive(0, 1, 2'b10, 0, 64'h4000, 64'h0, 5'd3);
        @(negedge clk);
        op_valid32 = 0;
        nr = 0;
        for (int k = 0; k < 40 && req32; k++) begin
            nr++;
            @(negedge clk);
        end
        chk("tmo_req_cycles", 64'(nr), 64'd16);
        chk("tmo_exc", 64'(excv32), 64'd1);
        chk("tmo_cause", 64'(cause32), 64'd3);
        chk("tmo_addr", 64'(exca32), 64'h4000);
        @(negedge clk);

        // Bus error
        drive(0, 1, 2'b10, 0, 64'h5000, 64'h0, 5'd4);
        @(negedge clk);
        op_valid32 = 0; ack32 = 1; err = 1;
        @(negedge clk);
        ack32 = 0; err = 0;
        chk("berr_exc", 64'(excv32), 64'd1);
        chk("berr_cause", 64'(cause32), 64'd2);
        chk("berr_addr", 64'(exca32), 64'h5000);
        chk("berr_no_ldv", 64'(ldv32), 64'd0);
        @(negedge clk);

        // Reset asserted during REQ
        drive(0, 1, 2'b10, 0, 64'h6000, 64'h0, 5'd5);
        @(negedge clk);
        op_valid32 = 0;
        chk("rstreq_req_before", 64'(req32), 64'd1);
        #2 rst = 1'b1;
        #1 chk("rstreq_req", 64'(req32), 64'd0);
        chk("rstreq_stall", 64'(stall32), 64'd0);
        chk("rstreq_ld_data", 64'(ldd32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // XLEN=64: LWU at 0xC
        drive(1, 1, 2'b10, 1, 64'hC, 64'h0, 5'd9);
        @(negedge clk);
        chk("lwu64_adr", adr64, 64'h8);
        chk("lwu64_mask", 64'(mask64), 64'hF0);
        rdata = 64'hFFFF_FFFF_0000_0000; ack64 = 1;
        @(negedge clk);
        ack64 = 0; op_valid64 = 0;
        chk("lwu64_ldv", 64'(ldv64), 64'd1);
        chk("lwu64_data", ldd64, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);

        // XLEN=64: LD at 0x8
        drive(1, 1, 2'b11, 0, 64'h8, 64'h0, 5'd10);
        @(negedge clk);
        chk("ld64_mask", 64'(mask64), 64'hFF);
        rdata = 64'h8000_0000_0000_0001; ack64 = 1;
        @(negedge clk);
        ack64 = 0; op_valid64 = 0;
        chk("ld64_data", ldd64, 64'h8000_0000_0000_0001);
        chk("ld64_rd", 64'(ldrd64), 64'd10);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
